// File: rtl/trigger_net_pkg.sv
// Shared types and helpers for the trigger network controller.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package trigger_net_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } net_state_t;

    // Widest counter the saturating helper can handle.
    localparam int unsigned SAT_MAX_W = 64;

    // Increment value, holding at the all-ones code of a width-bit counter.
    // Callers zero-extend into and truncate out of SAT_MAX_W bits.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] value,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] limit;
        if (width >= SAT_MAX_W) begin
            limit = '1;
        end else begin
            limit = (SAT_MAX_W'(1) << width) - SAT_MAX_W'(1);
        end
        sat_inc = (value >= limit) ? value : value + SAT_MAX_W'(1);
    endfunction

endpackage

// File: rtl/trigger_net_reduce.sv
// AND-reduces per-trigger sleep/sync_sleep/waited flags; flags all_sync_sleep rising edges.
// Latency: reductions are combinational (0 cycles); edge flag uses a 1-cycle registered history.
// Backpressure: none; pure broadcast of flags every cycle.
module trigger_net_reduce #(
    parameter int NUM_ACTORS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [NUM_ACTORS-1:0] sleep,
    input  logic [NUM_ACTORS-1:0] sync_sleep,
    input  logic [NUM_ACTORS-1:0] waited,
    output logic                  all_sleep,
    output logic                  all_sync_sleep,
    output logic                  all_waited,
    output logic                  sync_rise
);

    logic sync_prev;

    // Triggers consume these in the cycle they are produced, so no register here.
    assign all_sleep      = &sleep;
    assign all_sync_sleep = &sync_sleep;
    assign all_waited     = &waited;
    assign sync_rise      = all_sync_sleep & ~sync_prev;

    // Previous all_sync_sleep; cleared at run entry so a phase already active counts once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_prev <= 1'b0;
        end else if (clr) begin
            sync_prev <= 1'b0;
        end else begin
            sync_prev <= all_sync_sleep;
        end
    end

endmodule

// File: rtl/trigger_network_controller.sv
// Network scheduler: fans ap_start out to NUM_ACTORS triggers, reduces their flags, collects done.
// Latency: trig_start one cycle after ap_start is sampled; ap_done one cycle after the last done.
// Backpressure: each trig_start is held until its trigger is idle and accepts; optional watchdog
// (macro TRIGGER_NET_WATCHDOG_EN) aborts a run that stalls for WDOG_CYCLES without a new done.
module trigger_network_controller
    import trigger_net_pkg::*;
#(
    parameter int NUM_ACTORS  = 4,
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 1048576
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ap_start,
    output logic                  ap_done,
    output logic                  ap_idle,
    output logic                  ap_ready,
    output logic [NUM_ACTORS-1:0] trig_start,
    input  logic [NUM_ACTORS-1:0] trig_idle,
    input  logic [NUM_ACTORS-1:0] trig_done,
    input  logic [NUM_ACTORS-1:0] trig_sleep,
    input  logic [NUM_ACTORS-1:0] trig_sync_sleep,
    input  logic [NUM_ACTORS-1:0] trig_waited,
    output logic                  all_sleep,
    output logic                  all_sync_sleep,
    output logic                  all_waited,
`ifdef TRIGGER_NET_WATCHDOG_EN
    output logic                  wdog_error,
`endif
    output logic [CNT_W-1:0]      sync_rounds,
    output logic [CNT_W-1:0]      run_cycles
);

    // Reject configurations the counters and masks cannot represent.
    if (NUM_ACTORS < 1 || CNT_W < 1 || CNT_W > int'(SAT_MAX_W) || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("trigger_network_controller: unsupported parameter set");
    end

    net_state_t            state;
    net_state_t            state_nxt;
    logic [NUM_ACTORS-1:0] started_mask;
    logic [NUM_ACTORS-1:0] started_nxt;
    logic [NUM_ACTORS-1:0] done_mask;
    logic [NUM_ACTORS-1:0] done_nxt;
    logic                  run_entry;
    logic                  sync_rise;

    trigger_net_reduce #(
        .NUM_ACTORS (NUM_ACTORS)
    ) u_reduce (
        .clk            (ap_clk),
        .rst_n          (ap_rst_n),
        .clr            (run_entry),
        .sleep          (trig_sleep),
        .sync_sleep     (trig_sync_sleep),
        .waited         (trig_waited),
        .all_sleep      (all_sleep),
        .all_sync_sleep (all_sync_sleep),
        .all_waited     (all_waited),
        .sync_rise      (sync_rise)
    );

`ifdef TRIGGER_NET_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES) + 1;

    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_hit;

    assign wdog_hit = (state == RUN) && (wdog_cnt == WDOG_W'(WDOG_CYCLES));
`endif

    assign run_entry = (state == IDLE) && ap_start;

    // State register.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, start fan-out, done collection and kernel handshake outputs.
    always_comb begin
        state_nxt   = state;
        trig_start  = '0;
        ap_done     = 1'b0;
        ap_idle     = 1'b0;
        started_nxt = started_mask;
        done_nxt    = done_mask;
        case (state)
            IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                trig_start  = ~started_mask;
                started_nxt = started_mask | (~started_mask & trig_idle);
                // trig_done is also high while a trigger idles; only a busy, started one counts.
                done_nxt    = done_mask | (started_mask & trig_done & ~trig_idle);
                if (&done_nxt) begin
                    state_nxt = DONE;
                end
`ifdef TRIGGER_NET_WATCHDOG_EN
                if (wdog_hit) begin
                    state_nxt = DONE;
                end
`endif
            end
            DONE: begin
                ap_done   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign ap_ready = ap_done;

    // Run bookkeeping: masks and statistics clear on start, update in RUN, hold otherwise.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            started_mask <= '0;
            done_mask    <= '0;
            sync_rounds  <= '0;
            run_cycles   <= '0;
        end else if (run_entry) begin
            started_mask <= '0;
            done_mask    <= '0;
            sync_rounds  <= '0;
            run_cycles   <= '0;
        end else if (state == RUN) begin
            started_mask <= started_nxt;
            done_mask    <= done_nxt;
            run_cycles   <= CNT_W'(sat_inc(SAT_MAX_W'(run_cycles), CNT_W));
            if (sync_rise) begin
                sync_rounds <= CNT_W'(sat_inc(SAT_MAX_W'(sync_rounds), CNT_W));
            end
        end
    end

`ifdef TRIGGER_NET_WATCHDOG_EN
    // Stall watchdog: restarts on every newly finished trigger; error is sticky until next start.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            wdog_cnt   <= '0;
            wdog_error <= 1'b0;
        end else if (run_entry) begin
            wdog_cnt   <= '0;
            wdog_error <= 1'b0;
        end else if (state == RUN) begin
            if (|(done_nxt & ~done_mask)) begin
                wdog_cnt <= '0;
            end else begin
                wdog_cnt <= WDOG_W'(sat_inc(SAT_MAX_W'(wdog_cnt), WDOG_W));
            end
            if (wdog_hit) begin
                wdog_error <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_trigger_network_controller.sv
// Bench for trigger_network_controller: flag-reduction vector table plus run sequences
// driven by a small behavioural trigger model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_trigger_network_controller;

    localparam int N  = 4;
    localparam int CW = 32;
`ifdef TRIGGER_NET_WATCHDOG_EN
    localparam int WD = 100;
`else
    localparam int WD = 1048576;
`endif

    logic          ap_clk;
    logic          ap_rst_n;
    logic          ap_start;
    logic          ap_done;
    logic          ap_idle;
    logic          ap_ready;
    logic [N-1:0]  trig_start;
    logic [N-1:0]  trig_idle;
    logic [N-1:0]  trig_done;
    logic [N-1:0]  trig_sleep;
    logic [N-1:0]  trig_sync_sleep;
    logic [N-1:0]  trig_waited;
    logic          all_sleep;
    logic          all_sync_sleep;
    logic          all_waited;
    logic [CW-1:0] sync_rounds;
    logic [CW-1:0] run_cycles;
`ifdef TRIGGER_NET_WATCHDOG_EN
    logic          wdog_error;
`endif

    trigger_network_controller #(
        .NUM_ACTORS  (N),
        .CNT_W       (CW),
        .WDOG_CYCLES (WD)
    ) dut (
        .ap_clk          (ap_clk),
        .ap_rst_n        (ap_rst_n),
        .ap_start        (ap_start),
        .ap_done         (ap_done),
        .ap_idle         (ap_idle),
        .ap_ready        (ap_ready),
        .trig_start      (trig_start),
        .trig_idle       (trig_idle),
        .trig_done       (trig_done),
        .trig_sleep      (trig_sleep),
        .trig_sync_sleep (trig_sync_sleep),
        .trig_waited     (trig_waited),
        .all_sleep       (all_sleep),
        .all_sync_sleep  (all_sync_sleep),
        .all_waited      (all_waited),
`ifdef TRIGGER_NET_WATCHDOG_EN
        .wdog_error      (wdog_error),
`endif
        .sync_rounds     (sync_rounds),
        .run_cycles      (run_cycles)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Behavioural trigger: accepts a start while idle, stays busy, raises done after dur cycles,
    // then returns to idle (where done is also high, as real triggers do).
    logic [N-1:0] busy = '0;
    logic [N-1:0] hold_busy;
    logic [N-1:0] done_force;
    logic [N-1:0] done_now;
    logic         model_on;
    logic         model_clr;
    int           cnt [N];
    int           dur [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            done_now[i] = busy[i] && (cnt[i] == dur[i]);
        end
    end

    assign trig_idle = ~(busy | hold_busy);
    assign trig_done = model_on ? (~busy | done_now) : done_force;

    always @(posedge ap_clk) begin
        for (int i = 0; i < N; i++) begin
            if (model_clr) begin
                busy[i] <= 1'b0;
            end else if (!busy[i]) begin
                if (model_on && trig_start[i] && trig_idle[i]) begin
                    busy[i] <= 1'b1;
                    cnt[i]  <= 0;
                end
            end else if (cnt[i] == dur[i]) begin
                busy[i] <= 1'b0;
            end else begin
                cnt[i] <= cnt[i] + 1;
            end
        end
    end

    typedef struct {
        logic [N-1:0] sl;
        logic [N-1:0] ss;
        logic [N-1:0] wt;
        logic         e_sl;
        logic         e_ss;
        logic         e_wt;
    } red_vec_t;

    red_vec_t vecs [8];

    task automatic hard_reset();
        @(negedge ap_clk);
        ap_rst_n  = 1'b0;
        model_clr = 1'b1;
        @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        model_clr = 1'b0;
    endtask

    // Pulse ap_start in IDLE; returns at the falling edge inside RUN cycle 1.
    task automatic kick();
        @(negedge ap_clk);
        ap_start = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
    endtask

    // Advance until ap_done or budget; k is the cycle count on exit.
    task automatic wait_done(input int budget, inout int k);
        while (!ap_done && k < budget) begin
            @(negedge ap_clk);
            k++;
        end
    endtask

    logic [3:0] ss_pat [12];

    initial begin
        int k;
        int hi_cnt [N];
        int done_seen;

        ap_rst_n        = 1'b0;
        ap_start        = 1'b0;
        trig_sleep      = '0;
        trig_sync_sleep = '0;
        trig_waited     = '0;
        hold_busy       = '0;
        done_force      = '0;
        model_on        = 1'b1;
        model_clr       = 1'b1;
        for (int i = 0; i < N; i++) dur[i] = 10;

        vecs[0] = '{4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{4'hE, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{4'hF, 4'h7, 4'hF, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{4'hF, 4'hF, 4'hE, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{4'h1, 4'h8, 4'h3, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{4'hF, 4'hF, 4'h7, 1'b1, 1'b1, 1'b0};
        vecs[7] = '{4'h7, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1};

        ss_pat[0]  = 4'hF; ss_pat[1]  = 4'h7; ss_pat[2]  = 4'hF; ss_pat[3]  = 4'hF;
        ss_pat[4]  = 4'hF; ss_pat[5]  = 4'hF; ss_pat[6]  = 4'hF; ss_pat[7]  = 4'h0;
        ss_pat[8]  = 4'hB; ss_pat[9]  = 4'hF; ss_pat[10] = 4'h0; ss_pat[11] = 4'h0;

        repeat (2) @(negedge ap_clk);
        ap_rst_n  = 1'b1;
        model_clr = 1'b0;
        @(negedge ap_clk);

        // Reset state
        check("rst_idle", ap_idle, 1);
        check("rst_done", ap_done, 0);
        check("rst_ready", ap_ready, 0);
        check("rst_trig_start", trig_start, 0);
        check("rst_run_cycles", run_cycles, 0);
        check("rst_sync_rounds", sync_rounds, 0);
`ifdef TRIGGER_NET_WATCHDOG_EN
        check("rst_wdog", wdog_error, 0);
`endif

        // Combinational reductions, same-cycle, in IDLE
        for (int v = 0; v < 8; v++) begin
            trig_sleep      = vecs[v].sl;
            trig_sync_sleep = vecs[v].ss;
            trig_waited     = vecs[v].wt;
            #1;
            check($sformatf("vec%0d_all_sleep", v), all_sleep, vecs[v].e_sl);
            check($sformatf("vec%0d_all_sync_sleep", v), all_sync_sleep, vecs[v].e_ss);
            check($sformatf("vec%0d_all_waited", v), all_waited, vecs[v].e_wt);
            @(negedge ap_clk);
        end
        trig_sleep      = '0;
        trig_sync_sleep = '0;
        trig_waited     = '0;

        // Basic run: triggers finish after 10/20/30/40 cycles
        dur[0] = 10; dur[1] = 20; dur[2] = 30; dur[3] = 40;
        kick();
        k = 1;
        check("t1_start_c1", trig_start, 4'hF);
        check("t1_idle_c1", ap_idle, 0);
        @(negedge ap_clk);
        k = 2;
        check("t1_start_c2", trig_start, 4'h0);
        ap_start = 1'b1;               // ignored during RUN
        @(negedge ap_clk);
        k = 3;
        ap_start = 1'b0;
        wait_done(200, k);
        check("t1_done_cycle", k, 43);
        check("t1_run_cycles", run_cycles, 42);
        check("t1_ready", ap_ready, 1);
        check("t1_sync_rounds", sync_rounds, 0);
        ap_start = 1'b1;               // sampled in DONE: ignored
        @(negedge ap_clk);
        ap_start = 1'b0;
        check("t1_idle_after_done", ap_idle, 1);
        check("t1_done_drops", ap_done, 0);
        check("t1_run_cycles_hold", run_cycles, 42);

        // Trigger 2 busy with a previous run for 5 cycles after start
        for (int i = 0; i < N; i++) begin
            dur[i]    = 10;
            hi_cnt[i] = 0;
        end
        @(negedge ap_clk);
        ap_start  = 1'b1;
        hold_busy = 4'b0100;
        @(negedge ap_clk);
        ap_start = 1'b0;
        k = 1;
        while (k <= 8) begin
            if (k == 6) hold_busy = '0;
            #1;
            for (int i = 0; i < N; i++) hi_cnt[i] += int'(trig_start[i]);
            @(negedge ap_clk);
            k++;
        end
        check("t2_start0_cycles", hi_cnt[0], 1);
        check("t2_start1_cycles", hi_cnt[1], 1);
        check("t2_start2_cycles", hi_cnt[2], 6);
        check("t2_start3_cycles", hi_cnt[3], 1);
        wait_done(200, k);
        check("t2_done_cycle", k, 18);
        check("t2_run_cycles", run_cycles, 17);

        // Done leakage: done high while every trigger stays idle
        @(negedge ap_clk);
        model_on   = 1'b0;
        done_force = 4'hF;
        kick();
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            done_seen += int'(ap_done);
            @(negedge ap_clk);
        end
        check("t3_no_done", done_seen, 0);
        check("t3_done_mask", dut.done_mask, 0);
        check("t3_still_run", ap_idle, 0);
        check("t3_all_started", trig_start, 0);
        hard_reset();
        model_on   = 1'b1;
        done_force = '0;

        // Sync phases: three all-ones rising edges, one held for 5 cycles
        for (int i = 0; i < N; i++) dur[i] = 30;
        kick();
        k = 1;
        for (int c = 0; c < 12; c++) begin
            trig_sync_sleep = ss_pat[c];
            #1;
            check($sformatf("t4_all_sync_c%0d", c + 1), all_sync_sleep, &ss_pat[c]);
            @(negedge ap_clk);
            k++;
        end
        trig_sync_sleep = '0;
        wait_done(200, k);
        check("t4_done_cycle", k, 33);
        check("t4_sync_rounds", sync_rounds, 3);

        // Reset mid-run with started_mask = 0101
        @(negedge ap_clk);
        for (int i = 0; i < N; i++) dur[i] = 20;
        ap_start  = 1'b1;
        hold_busy = 4'b1010;
        @(negedge ap_clk);
        ap_start = 1'b0;
        repeat (2) @(negedge ap_clk);
        check("t5_started_mask", dut.started_mask, 4'b0101);
        check("t5_start_held", trig_start, 4'b1010);
        ap_rst_n = 1'b0;
        @(negedge ap_clk);
        check("t5_rst_idle", ap_idle, 1);
        check("t5_rst_trig_start", trig_start, 0);
        check("t5_rst_run_cycles", run_cycles, 0);
        check("t5_rst_sync_rounds", sync_rounds, 0);
        ap_rst_n  = 1'b1;
        hold_busy = '0;
        ap_start  = 1'b1;
        @(negedge ap_clk);
        ap_start = 1'b0;
        k = 1;
        check("t5_restart_c1", trig_start, 4'hF);
        @(negedge ap_clk);
        k = 2;
        check("t5_restart_c2", trig_start, 4'b0101);
        wait_done(200, k);
        check("t5_done_cycle", k, 41);
        check("t5_run_cycles", run_cycles, 40);
        hard_reset();

        // Trigger 3 never finishes
        dur[0] = 10; dur[1] = 20; dur[2] = 30; dur[3] = 100000;
        kick();
        k = 1;
        wait_done(300, k);
`ifdef TRIGGER_NET_WATCHDOG_EN
        check("t6_wdog_done_cycle", k, 134);
        check("t6_wdog_error", wdog_error, 1);
`else
        check("t6_no_done", ap_done, 0);
        check("t6_still_run", ap_idle, 0);
`endif
        hard_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
